// File: rtl/seg_pkg.sv
// seg_pkg: segment index encoding and default parameters for the segment register file.
package seg_pkg;

    typedef enum logic [2:0] {
        SEG_ES = 3'd0,
        SEG_CS = 3'd1,
        SEG_SS = 3'd2,
        SEG_DS = 3'd3
    } seg_idx_e;

    localparam int DEF_NUM_SEG   = 4;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_OFF_W     = 16;
    localparam int DEF_SEG_SHIFT = 4;
    localparam int DEF_ADDR_W    = 20;
    localparam int DEF_SEL_W     = 3;

    localparam logic [DEF_DATA_W-1:0] DEF_CS_RST_VAL = 16'hFFFF;

endpackage

// File: rtl/seg_addr_gen.sv
// seg_addr_gen: (segment << SEG_SHIFT) + offset, truncated to ADDR_W,
// held in a single valid/ready pipeline register.
module seg_addr_gen #(
    parameter int DATA_W    = 16,
    parameter int OFF_W     = 16,
    parameter int SEG_SHIFT = 4,
    parameter int ADDR_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ag_valid,
    output logic              ag_ready,
    input  logic [DATA_W-1:0] seg,
    input  logic [OFF_W-1:0]  off,
    input  logic              err,
    output logic              pa_valid,
    input  logic              pa_ready,
    output logic [ADDR_W-1:0] pa,
    output logic              pa_err
);

    logic [ADDR_W-1:0] sum;

    // Truncating before the add is safe: only the low ADDR_W bits survive anyway.
    assign sum      = (ADDR_W'(seg) << SEG_SHIFT) + ADDR_W'(off);
    assign ag_ready = !pa_valid || pa_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pa_valid <= 1'b0;
            pa       <= '0;
            pa_err   <= 1'b0;
        end else if (ag_valid && ag_ready) begin
            pa_valid <= 1'b1;
            pa       <= sum;
            pa_err   <= err;
        end else if (pa_ready) begin
            pa_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_reg_file.sv
// seg_reg_file: parametrised segment register bank with indexed read/write,
// physical-address generator with write bypass, and the SS-load interrupt shadow.
module seg_reg_file
    import seg_pkg::*;
#(
    parameter int                NUM_SEG    = DEF_NUM_SEG,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                OFF_W      = DEF_OFF_W,
    parameter int                SEG_SHIFT  = DEF_SEG_SHIFT,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CS_RST_VAL = DEF_CS_RST_VAL,
    parameter int                SEL_W      = DEF_SEL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [SEL_W-1:0]          wr_sel,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_SEG*DATA_W-1:0] seg_q,
    input  logic                      ag_valid,
    output logic                      ag_ready,
    input  logic [SEL_W-1:0]          ag_sel,
    input  logic [OFF_W-1:0]          ag_off,
    output logic                      pa_valid,
    input  logic                      pa_ready,
    output logic [ADDR_W-1:0]         pa,
    output logic                      pa_err,
    input  logic                      instr_done,
    output logic                      int_inhibit
);

    logic [DATA_W-1:0] regs [NUM_SEG];
    logic [DATA_W-1:0] ag_seg;
    logic              ag_bad;
    logic              ss_wr;
    logic              fresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++)
                regs[i] <= (i == int'(SEG_CS)) ? CS_RST_VAL : '0;
        end else begin
            for (int i = 0; i < NUM_SEG; i++)
                if (wr_en && wr_sel == SEL_W'(i))
                    regs[i] <= wr_data;
        end
    end

    // Out-of-range indexes match no entry, so both muxes fall back to zero.
    always_comb begin
        rd_data = '0;
        ag_seg  = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (rd_sel == SEL_W'(i))
                rd_data = regs[i];
            if (ag_sel == SEL_W'(i))
                ag_seg = (wr_en && wr_sel == ag_sel) ? wr_data : regs[i];
        end
    end

    assign ag_bad = 32'(ag_sel) >= NUM_SEG;

    for (genvar g = 0; g < NUM_SEG; g++)
        assign seg_q[g*DATA_W +: DATA_W] = regs[g];

    assign ss_wr = wr_en && wr_sel == SEL_W'(SEG_SS) && NUM_SEG > int'(SEG_SS);

    // fresh masks the retirement pulse of the SS-loading instruction itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_inhibit <= 1'b0;
            fresh       <= 1'b0;
        end else begin
            int_inhibit <= ss_wr ? 1'b1 : (instr_done && !fresh) ? 1'b0 : int_inhibit;
            fresh       <= ss_wr;
        end
    end

    seg_addr_gen #(
        .DATA_W    (DATA_W),
        .OFF_W     (OFF_W),
        .SEG_SHIFT (SEG_SHIFT),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .ag_valid (ag_valid),
        .ag_ready (ag_ready),
        .seg      (ag_seg),
        .off      (ag_off),
        .err      (ag_bad),
        .pa_valid (pa_valid),
        .pa_ready (pa_ready),
        .pa       (pa),
        .pa_err   (pa_err)
    );

endmodule

// File: tb/tb_seg_reg_file.sv
// tb_seg_reg_file: directed stimulus, per-cycle comparison against a behavioural
// model, plus hand-computed literal expectations.
module tb_seg_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic [2:0]  rd_sel;
    logic [15:0] rd_data;
    logic [63:0] seg_q;
    logic        ag_valid;
    logic        ag_ready;
    logic [2:0]  ag_sel;
    logic [15:0] ag_off;
    logic        pa_valid;
    logic        pa_ready;
    logic [19:0] pa;
    logic        pa_err;
    logic        instr_done;
    logic        int_inhibit;

    int n_chk = 0;
    int n_err = 0;

    seg_reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .seg_q       (seg_q),
        .ag_valid    (ag_valid),
        .ag_ready    (ag_ready),
        .ag_sel      (ag_sel),
        .ag_off      (ag_off),
        .pa_valid    (pa_valid),
        .pa_ready    (pa_ready),
        .pa          (pa),
        .pa_err      (pa_err),
        .instr_done  (instr_done),
        .int_inhibit (int_inhibit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain arrays and arithmetic from the register-file rules.
    logic [15:0] m_regs [4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    logic        m_pv  = 1'b0;
    logic [19:0] m_pa  = '0;
    logic        m_err = 1'b0;
    logic        m_inh = 1'b0;
    int          m_age = 0;

    always @(posedge clk or posedge rst) begin
        logic        acc;
        logic [15:0] sv;
        logic [31:0] sum;
        if (rst) begin
            m_regs = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
            m_pv   = 1'b0;
            m_pa   = '0;
            m_err  = 1'b0;
            m_inh  = 1'b0;
            m_age  = 0;
        end else begin
            acc = ag_valid && (!m_pv || pa_ready);
            sv  = 16'h0000;
            if (ag_sel < 3'd4)
                sv = (wr_en && wr_sel == ag_sel) ? wr_data : m_regs[ag_sel[1:0]];
            sum = {16'h0000, sv} * 32'd16 + {16'h0000, ag_off};
            if (acc) begin
                m_pv  = 1'b1;
                m_pa  = sum[19:0];
                m_err = ag_sel >= 3'd4;
            end else if (pa_ready) begin
                m_pv = 1'b0;
            end
            if (wr_en && wr_sel < 3'd4)
                m_regs[wr_sel[1:0]] = wr_data;
            if (wr_en && wr_sel == 3'd2) begin
                m_inh = 1'b1;
                m_age = 0;
            end else if (m_inh) begin
                if (instr_done && m_age >= 1)
                    m_inh = 1'b0;
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        chk("rd_data", {48'h0, rd_data}, {48'h0, (rd_sel < 3'd4) ? m_regs[rd_sel[1:0]] : 16'h0000});
        chk("seg_q", seg_q, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        chk("ag_ready", {63'h0, ag_ready}, {63'h0, !m_pv || pa_ready});
        chk("pa_valid", {63'h0, pa_valid}, {63'h0, m_pv});
        chk("int_inhibit", {63'h0, int_inhibit}, {63'h0, m_inh});
        if (m_pv) begin
            chk("pa", {44'h0, pa}, {44'h0, m_pa});
            chk("pa_err", {63'h0, pa_err}, {63'h0, m_err});
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wr_sel = 0; wr_data = 0; rd_sel = 3'd1;
        ag_valid = 0; ag_sel = 0; ag_off = 0; pa_ready = 1'b1; instr_done = 0;
        #3;
        chk("lit_rst_seg_q", seg_q, 64'h0000_0000_FFFF_0000);
        chk("lit_rst_rd_cs", {48'h0, rd_data}, 64'hFFFF);
        chk("lit_rst_pa_valid", {63'h0, pa_valid}, 64'h0);
        chk("lit_rst_inhibit", {63'h0, int_inhibit}, 64'h0);
        tick;
        rst = 1'b0;
        ag_valid = 1; ag_sel = 3'd1; ag_off = 16'h0010;
        tick;
        chk("lit_wrap_pa", {44'h0, pa}, 64'h00000);
        chk("lit_wrap_valid", {63'h0, pa_valid}, 64'h1);
        ag_valid = 0;
        wr_en = 1; wr_sel = 3'd3; wr_data = 16'h1234;
        tick;
        wr_en = 0; rd_sel = 3'd3;
        ag_valid = 1; ag_sel = 3'd3; ag_off = 16'h0005;
        #1;
        chk("lit_rd_ds", {48'h0, rd_data}, 64'h1234);
        tick;
        chk("lit_ds_pa", {44'h0, pa}, 64'h12345);
        ag_valid = 0;
        tick;
        chk("lit_single_valid", {63'h0, pa_valid}, 64'h0);
        wr_en = 1; wr_sel = 3'd0; wr_data = 16'hABCD;
        ag_valid = 1; ag_sel = 3'd0; ag_off = 16'h0000;
        tick;
        chk("lit_bypass_pa", {44'h0, pa}, 64'hABCD0);
        wr_sel = 3'd5; wr_data = 16'hFFFF; ag_valid = 0; rd_sel = 3'd5;
        tick;
        wr_en = 0;
        chk("lit_bad_write", seg_q, 64'h1234_0000_FFFF_ABCD);
        chk("lit_bad_read", {48'h0, rd_data}, 64'h0);
        pa_ready = 0; ag_valid = 1; ag_sel = 3'd3; ag_off = 16'h0006;
        tick;
        ag_off = 16'h0007;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lit_hold_ready", {63'h0, ag_ready}, 64'h0);
            chk("lit_hold_pa", {44'h0, pa}, 64'h12346);
            tick;
        end
        pa_ready = 1;
        #1;
        chk("lit_release_ready", {63'h0, ag_ready}, 64'h1);
        tick;
        chk("lit_release_pa", {44'h0, pa}, 64'h12347);
        ag_valid = 0;
        tick;
        wr_en = 1; wr_sel = 3'd2; wr_data = 16'h0100;
        tick;
        wr_en = 0;
        chk("lit_shadow_set", {63'h0, int_inhibit}, 64'h1);
        instr_done = 1;
        tick;
        instr_done = 0;
        chk("lit_shadow_first_pulse", {63'h0, int_inhibit}, 64'h1);
        tick;
        tick;
        instr_done = 1;
        chk("lit_shadow_before_second", {63'h0, int_inhibit}, 64'h1);
        tick;
        instr_done = 0;
        chk("lit_shadow_cleared", {63'h0, int_inhibit}, 64'h0);
        wr_en = 1; wr_sel = 3'd2; wr_data = 16'h0200;
        tick;
        instr_done = 1;
        tick;
        wr_en = 0;
        chk("lit_shadow_restart", {63'h0, int_inhibit}, 64'h1);
        tick;
        chk("lit_shadow_masked", {63'h0, int_inhibit}, 64'h1);
        wr_en = 1; wr_sel = 3'd3; wr_data = 16'h5555;
        tick;
        wr_en = 0; instr_done = 0;
        chk("lit_shadow_release", {63'h0, int_inhibit}, 64'h0);
        ag_valid = 1; ag_sel = 3'd7; ag_off = 16'h0020; pa_ready = 0;
        tick;
        ag_valid = 0;
        chk("lit_err_pa", {44'h0, pa}, 64'h00020);
        chk("lit_err_flag", {63'h0, pa_err}, 64'h1);
        rst = 1;
        #1;
        chk("lit_rst_mid_valid", {63'h0, pa_valid}, 64'h0);
        chk("lit_rst_mid_seg_q", seg_q, 64'h0000_0000_FFFF_0000);
        #1;
        rst = 0;
        tick;
        chk("lit_post_rst_valid", {63'h0, pa_valid}, 64'h0);
        pa_ready = 1;
        tick;
        tick;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
